// File: rtl/im_bus_read_arbiter.sv
// Two-requester round-robin arbiter for the instruction-memory AXI5-Lite read bus.
// AR is registered through a two-state FSM; R beats are steered back combinationally by RID.
module im_bus_read_arbiter #(
    parameter int ALEN    = 32,
    parameter int DLEN    = 32,
    parameter int ILEN    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             i_req0_arvalid,
    output logic                             o_req0_arready,
    input  logic [ALEN-1:0]                  i_req0_araddr,
    input  logic [2:0]                       i_req0_arprot,
    output logic                             o_req0_rvalid,
    input  logic                             i_req0_rready,
    output logic [DLEN-1:0]                  o_req0_rdata,
    output logic [1:0]                       o_req0_rresp,

    input  logic                             i_req1_arvalid,
    output logic                             o_req1_arready,
    input  logic [ALEN-1:0]                  i_req1_araddr,
    input  logic [2:0]                       i_req1_arprot,
    output logic                             o_req1_rvalid,
    input  logic                             i_req1_rready,
    output logic [DLEN-1:0]                  o_req1_rdata,
    output logic [1:0]                       o_req1_rresp,

    output logic                             o_im_bus_arvalid,
    input  logic                             i_im_bus_arready,
    output logic [ALEN-1:0]                  o_im_bus_araddr,
    output logic [2:0]                       o_im_bus_arprot,
    output logic [ILEN-1:0]                  o_im_bus_arid,

    input  logic                             i_im_bus_rvalid,
    output logic                             o_im_bus_rready,
    input  logic [DLEN-1:0]                  i_im_bus_rdata,
    input  logic [1:0]                       i_im_bus_rresp,
    input  logic [ILEN-1:0]                  i_im_bus_rid,

    output logic [$clog2(MAX_OUT+1)-1:0]     o_outstanding,
    output logic                             o_err_rid
);

    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ALEN-1:0]   araddr_q, araddr_d;
    logic [2:0]        arprot_q, arprot_d;
    logic [ILEN-1:0]   arid_q, arid_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic              err_rid_q, err_rid_d;

    logic              credit_ok;
    logic [CW:0]       inflight;
    logic              grant_valid;
    logic              grant_idx;
    logic              ar_hs;
    logic              rid_ok;
    logic              rid_sel;
    logic              r_hs;

    // A read still waiting in ISSUE already holds a credit.
    assign inflight  = {1'b0, outstanding_q} + {{CW{1'b0}}, state_q == ST_ISSUE};
    assign credit_ok = inflight < (CW+1)'(MAX_OUT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        if (state_q == ST_IDLE && credit_ok) begin
            if (i_req0_arvalid && i_req1_arvalid) begin
                grant_valid = 1'b1;
                grant_idx   = ~last_grant_q;
            end else if (i_req0_arvalid) begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end else if (i_req1_arvalid) begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
        end
    end

    assign ar_hs = (state_q == ST_ISSUE) && i_im_bus_arready;

    // FSM state register and all other sequential state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            araddr_q      <= '0;
            arprot_q      <= '0;
            arid_q        <= '0;
            outstanding_q <= '0;
            err_rid_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            araddr_q      <= araddr_d;
            arprot_q      <= arprot_d;
            arid_q        <= arid_d;
            outstanding_q <= outstanding_d;
            err_rid_q     <= err_rid_d;
        end
    end

    // FSM next-state and AR payload capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arprot_d     = arprot_q;
        arid_d       = arid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d      = ST_ISSUE;
                    last_grant_d = grant_idx;
                    araddr_d     = grant_idx ? i_req1_araddr : i_req0_araddr;
                    arprot_d     = grant_idx ? i_req1_arprot : i_req0_arprot;
                    arid_d       = ILEN'(grant_idx);
                end
            end
            ST_ISSUE: begin
                if (i_im_bus_arready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        o_req0_arready   = grant_valid && !grant_idx;
        o_req1_arready   = grant_valid && grant_idx;
        o_im_bus_arvalid = (state_q == ST_ISSUE);
    end

    assign o_im_bus_araddr = araddr_q;
    assign o_im_bus_arprot = arprot_q;
    assign o_im_bus_arid   = arid_q;

    // Only IDs 0/1 are legal, and only while a read is actually on the bus.
    assign rid_ok  = ((i_im_bus_rid >> 1) == '0) && (outstanding_q != '0);
    assign rid_sel = i_im_bus_rid[0];

    always_comb begin
        o_req0_rvalid   = 1'b0;
        o_req1_rvalid   = 1'b0;
        o_im_bus_rready = 1'b1;
        if (rid_ok) begin
            o_req0_rvalid   = i_im_bus_rvalid && !rid_sel;
            o_req1_rvalid   = i_im_bus_rvalid && rid_sel;
            o_im_bus_rready = rid_sel ? i_req1_rready : i_req0_rready;
        end
    end

    assign o_req0_rdata = i_im_bus_rdata;
    assign o_req0_rresp = i_im_bus_rresp;
    assign o_req1_rdata = i_im_bus_rdata;
    assign o_req1_rresp = i_im_bus_rresp;

    assign r_hs = i_im_bus_rvalid && rid_ok && o_im_bus_rready;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({ar_hs, r_hs})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        err_rid_d = err_rid_q || (i_im_bus_rvalid && !rid_ok);
    end

    assign o_outstanding = outstanding_q;
    assign o_err_rid     = err_rid_q;

endmodule

// File: tb/tb_im_bus_read_arbiter.sv
// Directed bench for im_bus_read_arbiter: per-cycle vector table plus hand-written
// sequences for credit exhaustion, AR back-pressure, R back-pressure and reset mid-ISSUE.
module tb_im_bus_read_arbiter;

    localparam logic [2:0] PROT0 = 3'b100;
    localparam logic [2:0] PROT1 = 3'b001;
    localparam logic [1:0] RESP  = 2'b10;

    logic        clk;
    logic        rst;
    logic        a0v, a1v;
    logic [31:0] a0a, a1a;
    logic        a0rdy, a1rdy;
    logic        r0v, r1v;
    logic        r0rdy, r1rdy;
    logic [31:0] r0data, r1data;
    logic [1:0]  r0resp, r1resp;
    logic        arv, arrdy;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic [3:0]  arid;
    logic        rv, rrdy;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [2:0]  outst;
    logic        err;

    int checks = 0;
    int errors = 0;

    im_bus_read_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .i_req0_arvalid   (a0v),
        .o_req0_arready   (a0rdy),
        .i_req0_araddr    (a0a),
        .i_req0_arprot    (PROT0),
        .o_req0_rvalid    (r0v),
        .i_req0_rready    (r0rdy),
        .o_req0_rdata     (r0data),
        .o_req0_rresp     (r0resp),
        .i_req1_arvalid   (a1v),
        .o_req1_arready   (a1rdy),
        .i_req1_araddr    (a1a),
        .i_req1_arprot    (PROT1),
        .o_req1_rvalid    (r1v),
        .i_req1_rready    (r1rdy),
        .o_req1_rdata     (r1data),
        .o_req1_rresp     (r1resp),
        .o_im_bus_arvalid (arv),
        .i_im_bus_arready (arrdy),
        .o_im_bus_araddr  (araddr),
        .o_im_bus_arprot  (arprot),
        .o_im_bus_arid    (arid),
        .i_im_bus_rvalid  (rv),
        .o_im_bus_rready  (rrdy),
        .i_im_bus_rdata   (rdata),
        .i_im_bus_rresp   (RESP),
        .i_im_bus_rid     (rid),
        .o_outstanding    (outst),
        .o_err_rid        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        a0v;
        logic [31:0] a0a;
        logic        a1v;
        logic [31:0] a1a;
        logic        arrdy;
        logic        rv;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic        r0rdy;
        logic        r1rdy;
        logic        x_a0rdy;
        logic        x_a1rdy;
        logic        x_arv;
        logic [31:0] x_addr;
        logic [3:0]  x_id;
        logic        x_r0v;
        logic        x_r1v;
        logic        x_rrdy;
        logic [2:0]  x_out;
        logic        x_err;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst   = 1'b0;
        a0v   = 1'b0; a0a = '0;
        a1v   = 1'b0; a1a = '0;
        arrdy = 1'b0;
        rv    = 1'b0; rid = '0; rdata = '0;
        r0rdy = 1'b0; r1rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table();
        vec_t v;
        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            @(negedge clk);
            rst = v.rst; a0v = v.a0v; a0a = v.a0a; a1v = v.a1v; a1a = v.a1a;
            arrdy = v.arrdy; rv = v.rv; rid = v.rid; rdata = v.rdata;
            r0rdy = v.r0rdy; r1rdy = v.r1rdy;
            #1;
            if (!v.rst) begin
                check($sformatf("row%0d req0_arready", i), a0rdy, v.x_a0rdy);
                check($sformatf("row%0d req1_arready", i), a1rdy, v.x_a1rdy);
                check($sformatf("row%0d bus_arvalid", i), arv, v.x_arv);
                check($sformatf("row%0d bus_araddr", i), araddr, v.x_addr);
                check($sformatf("row%0d bus_arid", i), arid, v.x_id);
                check($sformatf("row%0d req0_rvalid", i), r0v, v.x_r0v);
                check($sformatf("row%0d req1_rvalid", i), r1v, v.x_r1v);
                check($sformatf("row%0d bus_rready", i), rrdy, v.x_rrdy);
                check($sformatf("row%0d outstanding", i), outst, v.x_out);
                check($sformatf("row%0d err_rid", i), err, v.x_err);
                if (v.x_arv)
                    check($sformatf("row%0d bus_arprot", i), arprot, v.x_id[0] ? PROT1 : PROT0);
                if (v.x_r0v) begin
                    check($sformatf("row%0d req0_rdata", i), r0data, v.rdata);
                    check($sformatf("row%0d req0_rresp", i), r0resp, RESP);
                end
                if (v.x_r1v) begin
                    check($sformatf("row%0d req1_rdata", i), r1data, v.rdata);
                    check($sformatf("row%0d req1_rresp", i), r1resp, RESP);
                end
            end
        end
    endtask

    int n_ar;
    int n_dlv;

    initial begin
        idle_inputs();
        rst = 1'b1;

        //        rst a0v a0a    a1v a1a    arr rv rid rdata         r0r r1r | a0r a1r arv addr   id r0v r1v rrdy out err
        vt.push_back(vec_t'{1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0});
        // single read from requester 0
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 0});
        vt.push_back(vec_t'{0, 1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  1, 0, 0, 32'h0,   0, 0, 0, 1, 0, 0});
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0,        0, 0,  0, 0, 1, 32'h100, 0, 0, 0, 1, 0, 0});
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'hDEADBEEF, 1, 0,  0, 0, 0, 32'h100, 0, 1, 0, 1, 1, 0});
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h100, 0, 0, 0, 1, 0, 0});
        vt.push_back(vec_t'{1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0});
        // both requesters streaming: grants alternate, req0 first, stalls at four in flight
        vt.push_back(vec_t'{0, 1, 32'h10,  1, 32'h20,  1, 0, 0, 32'h0,        0, 0,  1, 0, 0, 32'h0,   0, 0, 0, 1, 0, 0});
        vt.push_back(vec_t'{0, 1, 32'h14,  1, 32'h20,  1, 0, 0, 32'h0,        0, 0,  0, 0, 1, 32'h10,  0, 0, 0, 1, 0, 0});
        vt.push_back(vec_t'{0, 1, 32'h14,  1, 32'h20,  1, 0, 0, 32'h0,        0, 0,  0, 1, 0, 32'h10,  0, 0, 0, 0, 1, 0});
        vt.push_back(vec_t'{0, 1, 32'h14,  1, 32'h24,  1, 0, 0, 32'h0,        0, 0,  0, 0, 1, 32'h20,  1, 0, 0, 0, 1, 0});
        vt.push_back(vec_t'{0, 1, 32'h14,  1, 32'h24,  1, 0, 0, 32'h0,        0, 0,  1, 0, 0, 32'h20,  1, 0, 0, 0, 2, 0});
        vt.push_back(vec_t'{0, 1, 32'h18,  1, 32'h24,  1, 0, 0, 32'h0,        0, 0,  0, 0, 1, 32'h14,  0, 0, 0, 0, 2, 0});
        vt.push_back(vec_t'{0, 1, 32'h18,  1, 32'h24,  1, 0, 0, 32'h0,        0, 0,  0, 1, 0, 32'h14,  0, 0, 0, 0, 3, 0});
        vt.push_back(vec_t'{0, 1, 32'h18,  1, 32'h28,  1, 0, 0, 32'h0,        0, 0,  0, 0, 1, 32'h24,  1, 0, 0, 0, 3, 0});
        vt.push_back(vec_t'{0, 1, 32'h18,  1, 32'h28,  1, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h24,  1, 0, 0, 0, 4, 0});
        vt.push_back(vec_t'{0, 1, 32'h18,  1, 32'h28,  1, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h24,  1, 0, 0, 0, 4, 0});
        vt.push_back(vec_t'{1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0});
        // illegal RID and response with nothing outstanding: dropped, sticky error until reset
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 1, 2, 32'h1234,     0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 0});
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 1});
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h99,       1, 0,  0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 1});
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 1});
        vt.push_back(vec_t'{1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0});
        vt.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 0});

        run_table();

        // Credit exhaustion: four ARs, then blocked until one beat retires.
        do_reset();
        n_ar = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a0v = 1'b1; a0a = 32'h200; arrdy = 1'b1;
            #1;
            if (arv && arrdy) n_ar++;
        end
        check("credit ar_count", n_ar, 4);
        check("credit req0_arready_blocked", a0rdy, 1'b0);
        check("credit outstanding_full", outst, 3'd4);
        @(negedge clk);
        rv = 1'b1; rid = 4'd0; rdata = 32'h55; r0rdy = 1'b1;
        #1;
        check("credit retire_rvalid", r0v, 1'b1);
        check("credit retire_rready", rrdy, 1'b1);
        @(negedge clk);
        rv = 1'b0; r0rdy = 1'b0;
        #1;
        check("credit outstanding_after_retire", outst, 3'd3);
        check("credit req0_arready_reopen", a0rdy, 1'b1);
        n_ar = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (arv && arrdy) n_ar++;
        end
        check("credit fifth_ar_count", n_ar, 1);
        check("credit outstanding_refull", outst, 3'd4);

        // Bus AR back-pressure: payload stable, no requester accepted.
        do_reset();
        @(negedge clk);
        a0v = 1'b1; a0a = 32'h300; arrdy = 1'b0;
        #1;
        check("stall grant", a0rdy, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a0v = 1'b1; a0a = 32'h304; a1v = 1'b1; a1a = 32'h380; arrdy = 1'b0;
            #1;
            check($sformatf("stall%0d arvalid", c), arv, 1'b1);
            check($sformatf("stall%0d araddr", c), araddr, 32'h300);
            check($sformatf("stall%0d arid", c), arid, 4'd0);
            check($sformatf("stall%0d req0_arready", c), a0rdy, 1'b0);
            check($sformatf("stall%0d req1_arready", c), a1rdy, 1'b0);
        end
        @(negedge clk);
        arrdy = 1'b1;
        #1;
        check("stall release_arvalid", arv, 1'b1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("stall outstanding", outst, 3'd1);

        // R back-pressure from requester 1, then delivery concurrent with an AR handshake.
        do_reset();
        @(negedge clk);
        a1v = 1'b1; a1a = 32'h400;
        #1;
        check("rbp req1_grant", a1rdy, 1'b1);
        @(negedge clk);
        a1v = 1'b0; arrdy = 1'b1;
        #1;
        check("rbp bus_arid", arid, 4'd1);
        @(negedge clk);
        arrdy = 1'b0;
        #1;
        check("rbp outstanding_1", outst, 3'd1);
        n_dlv = 0;
        @(negedge clk);
        rv = 1'b1; rid = 4'd1; rdata = 32'hCAFE0001; r1rdy = 1'b0;
        a0v = 1'b1; a0a = 32'h500;
        #1;
        if (r1v && r1rdy) n_dlv++;
        check("rbp hold0_rready", rrdy, 1'b0);
        check("rbp hold0_req1_rvalid", r1v, 1'b1);
        check("rbp hold0_req0_rvalid", r0v, 1'b0);
        check("rbp hold0_req0_grant", a0rdy, 1'b1);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            a0v = 1'b0;
            #1;
            if (r1v && r1rdy) n_dlv++;
            check($sformatf("rbp hold%0d_rready", c), rrdy, 1'b0);
            check($sformatf("rbp hold%0d_arvalid", c), arv, 1'b1);
            check($sformatf("rbp hold%0d_outstanding", c), outst, 3'd1);
        end
        @(negedge clk);
        r1rdy = 1'b1; arrdy = 1'b1;
        #1;
        if (r1v && r1rdy) n_dlv++;
        check("rbp deliver_rready", rrdy, 1'b1);
        check("rbp deliver_rdata", r1data, 32'hCAFE0001);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rbp outstanding_unchanged", outst, 3'd1);
        check("rbp deliveries", n_dlv, 1);
        check("rbp arvalid_done", arv, 1'b0);

        // Reset while a read is parked in ISSUE with another already in flight.
        do_reset();
        @(negedge clk);
        a0v = 1'b1; a0a = 32'h600;
        @(negedge clk);
        a0v = 1'b0; arrdy = 1'b1;
        @(negedge clk);
        arrdy = 1'b0;
        #1;
        check("rstmid outstanding_pre", outst, 3'd1);
        @(negedge clk);
        a0v = 1'b1; a0a = 32'h604;
        @(negedge clk);
        a0v = 1'b0;
        #1;
        check("rstmid in_issue", arv, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid arvalid", arv, 1'b0);
        check("rstmid outstanding", outst, 3'd0);
        check("rstmid araddr", araddr, 32'h0);
        @(negedge clk);
        rv = 1'b1; rid = 4'd0; r0rdy = 1'b1;
        #1;
        check("rstmid stale_rvalid", r0v, 1'b0);
        check("rstmid stale_rready", rrdy, 1'b1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rstmid stale_err", err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
